sat_accum_bank: RTL and testbench
=================================

# sat_accum_bank

Multi-channel saturating accumulator bank, the registered, parametrised successor of the team's combinational capped adder. Each of `NUM_CH` channels holds a signed `BITWIDTH`-bit running sum. Each accepted sample is added to or subtracted from its channel's sum, clamped to the signed range (or wrapped, by parameter), and reported on a valid/ready output port with a per-operation saturation flag. It sits between the sample front-end and downstream integrators, replacing ad-hoc adder-plus-register pairs.

## Interface

Parameters:
- `BITWIDTH`, default 32: signed width of data and accumulators (≥ 2).
- `NUM_CH`, default 4: number of independent accumulators (≥ 1).
- `WRAP`, default 0: 0 = saturate on overflow; 1 = two's-complement wrap, with `out_sat` still reporting that overflow occurred.
- `CH_W`, default `max(1, $clog2(NUM_CH))`: channel index width (derived).

Ports:
- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `in_valid`, in, 1: sample present.
- `in_ready`, out, 1: sample accepted when `in_valid & in_ready`.
- `in_ch`, in, `CH_W`: target channel. Values ≥ `NUM_CH` are accepted, discarded, and produce no output.
- `in_data`, in, `BITWIDTH`: signed operand.
- `in_sub`, in, 1: 0 = acc + data; 1 = acc − data.
- `clr`, in, 1: clear request for one cycle; needs no handshake.
- `clr_all`, in, 1: with `clr`, clears every channel; otherwise only `clr_ch` is cleared.
- `clr_ch`, in, `CH_W`: channel to clear.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: result consumed when `out_valid & out_ready`.
- `out_ch`, out, `CH_W`: channel of the result.
- `out_sum`, out, `BITWIDTH`: new accumulator value after the operation.
- `out_sat`, out, 1: this operation overflowed.
- `sat_sticky`, out, `NUM_CH`: per-channel sticky overflow flags.

## Operation

- Exact result is formed in `BITWIDTH+2` signed bits: sign-extended acc ± sign-extended data.
  - Subtracting MIN is therefore exact; there is no negation overflow.
- Overflow occurs when the exact result is above MAX = 2^(BITWIDTH−1)−1 or below MIN = −2^(BITWIDTH−1).
  - `WRAP`=0: clamp to MAX or MIN.
  - `WRAP`=1: keep the low `BITWIDTH` bits.
- On accept:
  - `acc[in_ch]` ← result.
  - Output register loads {`in_ch`, result, overflow}.
  - `sat_sticky[in_ch]` is set if overflow.
- Clear: `acc` ← 0 and `sat_sticky` ← 0 for the selected channel(s). A pending output register is not affected.
- Clear and accept on the same channel in the same cycle: the clear applies first. The operation uses 0 as the old value, and the sticky bit then reflects this operation only.
- Clear and accept on different channels in the same cycle: both take effect.
- Output back-pressure: `in_ready = rst_n & (!out_valid | out_ready)`. `out_*` hold stable while `out_valid & !out_ready`.
- Back-to-back samples to the same channel need no stall, because the accumulator updates on the accepting edge.

## Timing

- Latency: a sample accepted at edge N has its result valid from edge N (visible in cycle N+1).
- Throughput: one sample per clock while `out_ready`=1.
- Reset (edge with `rst_n`=0), regardless of state or pending output:
  - All `acc` = 0, `sat_sticky` = 0.
  - `out_valid` = 0, `out_ch` = 0, `out_sum` = 0, `out_sat` = 0.
  - `in_ready` = 0 while `rst_n` = 0; a result pending at reset is dropped.
- There is no FSM beyond the output-valid bit: EMPTY (`out_valid`=0) ↔ FULL (`out_valid`=1).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on consume without a new accept.
  - FULL→FULL on consume with a same-cycle accept.

## Structure

- Package `sat_pkg` holds:
  - MAX/MIN constant functions of width.
  - A `sat_op_e` enum (ADD, SUB).
  - The shared clamp function, so other blocks saturate identically.
- One combinational sub-module, `sat_addsub`: a width-parametrised add/subtract with clamp-or-wrap, giving {result, overflow}. The bank instantiates it once and muxes the accumulator operand by channel.

## Test plan

All scenarios use `BITWIDTH`=8, `NUM_CH`=4, `WRAP`=0 unless stated.

- Reset, then 100+27 on ch0 → 127, then 127+1 → `out_sum`=127, `out_sat`=1, `sat_sticky`=0001.
- ch1: 0−100 → −100, then −100−(−128) → 28, `out_sat`=0. Exact subtraction of MIN.
- ch2: −100 + −100 → −128 with `out_sat`=1. Same stimulus with `WRAP`=1 → 56 with `out_sat`=1.
- Hold `out_ready`=0 for 3 cycles after an accept → `in_ready`=0 and `out_*` stable. A same-cycle consume+accept stream of 10 samples gives 10 results with no bubbles.
- Simultaneous `clr` ch0 and accept ch0 (+5) with `acc`=127 and sticky set → `out_sum`=5, sticky bit0=0. `clr_all` concurrent with an accept on ch3 → ch3 result equals data.
- Assert `rst_n`=0 while `out_valid`=1 with `out_ready`=0 → after the reset edge all outputs are 0, and the following accept of 7 on ch0 yields 7.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared saturation helpers: MAX/MIN limits for a given signed width, the
// add/sub operation enum, and the common clamp/overflow functions so every
// block that saturates does so identically.
package sat_pkg;

  // Widest accumulator the helpers support; exact results carry two guard bits.
  localparam int unsigned SAT_MAX_W  = 64;
  localparam int unsigned SAT_WIDE_W = SAT_MAX_W + 2;

  typedef logic signed [SAT_WIDE_W-1:0] sat_wide_t;

  typedef enum logic {
    SAT_ADD = 1'b0,
    SAT_SUB = 1'b1
  } sat_op_e;

  // Largest signed value representable in w bits.
  function automatic sat_wide_t sat_max(input int unsigned w);
    return (sat_wide_t'(1) << (w - 1)) - sat_wide_t'(1);
  endfunction

  // Smallest signed value representable in w bits.
  function automatic sat_wide_t sat_min(input int unsigned w);
    return -(sat_wide_t'(1) << (w - 1));
  endfunction

  // True when x does not fit in a signed w-bit field.
  function automatic logic sat_ovf(input sat_wide_t x, input int unsigned w);
    return (x > sat_max(w)) || (x < sat_min(w));
  endfunction

  // Clamp x into the signed w-bit range.
  function automatic sat_wide_t sat_clamp(input sat_wide_t x, input int unsigned w);
    sat_wide_t r;
    r = x;
    if (x > sat_max(w)) begin
      r = sat_max(w);
    end else if (x < sat_min(w)) begin
      r = sat_min(w);
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_addsub.sv
// Combinational signed add/subtract with clamp-or-wrap on overflow.
//   a, b      : signed W-bit operands
//   op        : SAT_ADD (a + b) or SAT_SUB (a - b)
//   result_c  : clamped (WRAP=0) or low W bits (WRAP=1) of the exact result
//   ovf_c     : exact result fell outside the signed W-bit range
module sat_addsub
  import sat_pkg::*;
#(
  parameter int unsigned W    = 32,
  parameter bit          WRAP = 1'b0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  sat_op_e      op,
  output logic [W-1:0] result_c,
  output logic         ovf_c
);

  localparam int unsigned XW = W + 2;

  logic signed [XW-1:0] a_x;
  logic signed [XW-1:0] b_x;
  logic signed [XW-1:0] exact;
  sat_wide_t            wide;
  sat_wide_t            clamped;

  // Two guard bits make a - MIN and MIN + MIN exact before the range check.
  always_comb begin
    a_x     = {{2{a[W-1]}}, a};
    b_x     = {{2{b[W-1]}}, b};
    exact   = (op == SAT_SUB) ? (a_x - b_x) : (a_x + b_x);
    wide    = sat_wide_t'(exact);
    clamped = sat_clamp(wide, W);
    ovf_c   = sat_ovf(wide, W);
    result_c = WRAP ? W'(exact) : W'(clamped);
  end

endmodule

// File: rtl/sat_accum_bank.sv
// Multi-channel saturating accumulator bank with a registered valid/ready
// result port.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : sample handshake; in_ch, in_data, in_sub carry the op
//   clr, clr_all, clr_ch: one-cycle clear of one channel or all channels
//   out_valid/out_ready : result handshake; out_ch, out_sum, out_sat carry it
//   sat_sticky          : per-channel overflow flags since last clear/reset
module sat_accum_bank
  import sat_pkg::*;
#(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned NUM_CH   = 4,
  parameter bit          WRAP     = 1'b0,
  parameter int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic                in_sub,
  input  logic                clr,
  input  logic                clr_all,
  input  logic [CH_W-1:0]     clr_ch,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_ch,
  output logic [BITWIDTH-1:0] out_sum,
  output logic                out_sat,
  output logic [NUM_CH-1:0]   sat_sticky
);

  logic [BITWIDTH-1:0] acc [NUM_CH];

  logic                accept_c;
  logic                ch_ok_c;
  logic                clr_hit_in_c;
  logic [BITWIDTH-1:0] acc_old_c;
  logic [BITWIDTH-1:0] res_c;
  logic                ovf_c;

  // The output register is the only buffering; a new sample may enter
  // whenever it is empty or being drained this cycle.
  assign in_ready     = rst_n & (~out_valid | out_ready);
  assign accept_c     = in_valid & in_ready;
  assign ch_ok_c      = 32'(in_ch) < NUM_CH;
  assign clr_hit_in_c = clr & (clr_all | (clr_ch == in_ch));

  // A same-cycle clear of the target channel makes the old value zero.
  always_comb begin
    acc_old_c = '0;
    if (ch_ok_c && !clr_hit_in_c) begin
      acc_old_c = acc[in_ch];
    end
  end

  sat_addsub #(
    .W    (BITWIDTH),
    .WRAP (WRAP)
  ) u_addsub (
    .a        (acc_old_c),
    .b        (in_data),
    .op       (sat_op_e'(in_sub)),
    .result_c (res_c),
    .ovf_c    (ovf_c)
  );

  // Accumulator, sticky and output-register state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
      end
      sat_sticky <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_sum    <= '0;
      out_sat    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept_c && ch_ok_c && (in_ch == CH_W'(i))) begin
          acc[i]        <= res_c;
          // A cleared channel's sticky reflects only this operation.
          sat_sticky[i] <= ovf_c | (sat_sticky[i] & ~clr_hit_in_c);
        end else if (clr && (clr_all || (clr_ch == CH_W'(i)))) begin
          acc[i]        <= '0;
          sat_sticky[i] <= 1'b0;
        end
      end

      // Out-of-range channels are swallowed without producing a result.
      if (accept_c && ch_ok_c) begin
        out_valid <= 1'b1;
        out_ch    <= in_ch;
        out_sum   <= res_c;
        out_sat   <= ovf_c;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sat_accum_bank.sv
// Self-checking bench for sat_accum_bank: a saturating and a wrapping
// instance share stimulus and are compared against an integer reference model.
module tb_sat_accum_bank;

  localparam int unsigned BW  = 8;
  localparam int unsigned NCH = 4;
  localparam int unsigned CHW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [CHW-1:0] in_ch = '0;
  logic [BW-1:0]  in_data = '0;
  logic           in_sub = 1'b0;
  logic           clr = 1'b0;
  logic           clr_all = 1'b0;
  logic [CHW-1:0] clr_ch = '0;
  logic           out_ready = 1'b1;

  logic           s_in_ready, s_out_valid, s_out_sat;
  logic [CHW-1:0] s_out_ch;
  logic [BW-1:0]  s_out_sum;
  logic [NCH-1:0] s_sticky;
  logic           w_in_ready, w_out_valid, w_out_sat;
  logic [CHW-1:0] w_out_ch;
  logic [BW-1:0]  w_out_sum;
  logic [NCH-1:0] w_sticky;

  always #5 clk = ~clk;

  sat_accum_bank #(.BITWIDTH(BW), .NUM_CH(NCH), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ch(in_ch), .in_data(in_data), .in_sub(in_sub), .clr(clr),
    .clr_all(clr_all), .clr_ch(clr_ch), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_ch(s_out_ch), .out_sum(s_out_sum),
    .out_sat(s_out_sat), .sat_sticky(s_sticky)
  );

  sat_accum_bank #(.BITWIDTH(BW), .NUM_CH(NCH), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_ch(in_ch), .in_data(in_data), .in_sub(in_sub), .clr(clr),
    .clr_all(clr_all), .clr_ch(clr_ch), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_ch(w_out_ch), .out_sum(w_out_sum),
    .out_sat(w_out_sat), .sat_sticky(w_sticky)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: index 0 = saturating bank, 1 = wrapping bank.
  int m_acc [2][NCH];
  bit m_stk [2][NCH];
  bit m_ov;
  int exp_sum [2];
  bit exp_sat [2];
  int exp_ch;
  bit ro, re;

  function automatic int sv(input logic [BW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [NCH-1:0] stk_vec(input int k);
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_stk[k][i];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NCH; i++) begin
        m_acc[k][i] = 0;
        m_stk[k][i] = 1'b0;
      end
      exp_sum[k] = 0;
      exp_sat[k] = 1'b0;
    end
    exp_ch = 0;
    m_ov   = 1'b0;
  endtask

  task automatic model_clear(input int c, input bit all);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NCH; i++)
        if (all || i == c) begin
          m_acc[k][i] = 0;
          m_stk[k][i] = 1'b0;
        end
  endtask

  task automatic model_accept(input int ch, input int data, input bit sub);
    int exact, r;
    bit ovf;
    for (int k = 0; k < 2; k++) begin
      exact = sub ? (m_acc[k][ch] - data) : (m_acc[k][ch] + data);
      ovf   = (exact > 127) || (exact < -128);
      if (k == 0) r = (exact > 127) ? 127 : ((exact < -128) ? -128 : exact);
      else        r = (((exact + 128) % 256) + 256) % 256 - 128;
      m_acc[k][ch] = r;
      m_stk[k][ch] = m_stk[k][ch] | ovf;
      exp_sum[k]   = r;
      exp_sat[k]   = ovf;
    end
    exp_ch = ch;
  endtask

  // Drive one cycle of stimulus and advance the model at the clock edge.
  task automatic apply(input bit v, input int ch, input int data, input bit sub,
                       input bit c, input bit ca, input int cch,
                       output bit rdy_obs, output bit rdy_exp);
    in_valid = v; in_ch = CHW'(ch); in_data = BW'(data); in_sub = sub;
    clr = c; clr_all = ca; clr_ch = CHW'(cch);
    #1;
    rdy_obs = s_in_ready;
    rdy_exp = !m_ov || out_ready;
    @(posedge clk);
    if (c) model_clear(cch, ca);
    if (v && rdy_exp) begin
      model_accept(ch, data, sub);
      m_ov = 1'b1;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    #1;
    in_valid = 1'b0; clr = 1'b0; clr_all = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (s_in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", s_in_ready); else passed++;
    total++; if (s_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", s_out_valid); else passed++;
    total++; if (s_out_sum !== '0 || s_out_ch !== '0 || s_out_sat !== 1'b0)
      $display("FAIL reset_out_fields: sum=%h ch=%h sat=%b want 0", s_out_sum, s_out_ch, s_out_sat); else passed++;
    total++; if (s_sticky !== '0 || w_sticky !== '0) $display("FAIL reset_sticky: got %b/%b want 0", s_sticky, w_sticky); else passed++;
    total++; if (w_out_valid !== 1'b0) $display("FAIL reset_wrap_valid: got %b want 0", w_out_valid); else passed++;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_saturate_pos();
    apply(1, 0, 100, 0, 0, 0, 0, ro, re);
    apply(1, 0, 27, 0, 0, 0, 0, ro, re);
    total++; if (sv(s_out_sum) != 127 || s_out_sat !== 1'b0 || s_out_ch !== 2'd0)
      $display("FAIL ch0_reach_max: sum=%0d sat=%b want 127 0", sv(s_out_sum), s_out_sat); else passed++;
    apply(1, 0, 1, 0, 0, 0, 0, ro, re);
    total++; if (sv(s_out_sum) != 127 || s_out_sat !== 1'b1)
      $display("FAIL ch0_clamp_max: sum=%0d sat=%b want 127 1", sv(s_out_sum), s_out_sat); else passed++;
    total++; if (s_sticky !== 4'b0001) $display("FAIL ch0_sticky: got %b want 0001", s_sticky); else passed++;
    total++; if (sv(w_out_sum) != -128 || w_out_sat !== 1'b1)
      $display("FAIL ch0_wrap_max: sum=%0d sat=%b want -128 1", sv(w_out_sum), w_out_sat); else passed++;
  endtask

  task automatic test_sub_min();
    apply(1, 1, 100, 1, 0, 0, 0, ro, re);
    total++; if (sv(s_out_sum) != -100 || s_out_ch !== 2'd1)
      $display("FAIL ch1_sub: sum=%0d ch=%0d want -100 1", sv(s_out_sum), s_out_ch); else passed++;
    apply(1, 1, -128, 1, 0, 0, 0, ro, re);
    total++; if (sv(s_out_sum) != 28 || s_out_sat !== 1'b0)
      $display("FAIL ch1_sub_min: sum=%0d sat=%b want 28 0", sv(s_out_sum), s_out_sat); else passed++;
  endtask

  task automatic test_saturate_neg();
    apply(1, 2, -100, 0, 0, 0, 0, ro, re);
    apply(1, 2, -100, 0, 0, 0, 0, ro, re);
    total++; if (sv(s_out_sum) != -128 || s_out_sat !== 1'b1)
      $display("FAIL ch2_clamp_min: sum=%0d sat=%b want -128 1", sv(s_out_sum), s_out_sat); else passed++;
    total++; if (sv(w_out_sum) != 56 || w_out_sat !== 1'b1)
      $display("FAIL ch2_wrap_min: sum=%0d sat=%b want 56 1", sv(w_out_sum), w_out_sat); else passed++;
    total++; if (s_sticky !== 4'b0101) $display("FAIL ch2_sticky: got %b want 0101", s_sticky); else passed++;
  endtask

  task automatic test_backpressure();
    apply(0, 0, 0, 0, 0, 0, 0, ro, re);
    out_ready = 1'b0;
    apply(1, 3, 10, 0, 0, 0, 0, ro, re);
    total++; if (s_out_valid !== 1'b1 || sv(s_out_sum) != 10 || s_out_ch !== 2'd3)
      $display("FAIL bp_first: valid=%b sum=%0d ch=%0d want 1 10 3", s_out_valid, sv(s_out_sum), s_out_ch); else passed++;
    for (int i = 0; i < 3; i++) begin
      apply(1, 3, 20, 0, 0, 0, 0, ro, re);
      total++; if (ro !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", i, ro); else passed++;
      total++; if (s_out_valid !== 1'b1 || sv(s_out_sum) != 10 || s_out_ch !== 2'd3 || s_out_sat !== 1'b0)
        $display("FAIL bp_hold[%0d]: valid=%b sum=%0d ch=%0d sat=%b want 1 10 3 0",
                 i, s_out_valid, sv(s_out_sum), s_out_ch, s_out_sat); else passed++;
    end
    out_ready = 1'b1;
    apply(1, 3, 20, 0, 0, 0, 0, ro, re);
    total++; if (sv(s_out_sum) != 30 || s_out_valid !== 1'b1)
      $display("FAIL bp_release: sum=%0d valid=%b want 30 1", sv(s_out_sum), s_out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    int results;
    results = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply(1, int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 255)) - 128,
            bit'($urandom_range(0, 1)), 0, 0, 0, ro, re);
      total++; if (ro !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", i, ro); else passed++;
      if (s_out_valid === 1'b1) results++;
      total++; if (sv(s_out_sum) != exp_sum[0] || s_out_ch !== CHW'(exp_ch) || s_out_sat !== exp_sat[0])
        $display("FAIL b2b_result[%0d]: sum=%0d ch=%0d sat=%b want %0d %0d %b",
                 i, sv(s_out_sum), s_out_ch, s_out_sat, exp_sum[0], exp_ch, exp_sat[0]); else passed++;
    end
    total++; if (results != 10) $display("FAIL b2b_count: got %0d want 10", results); else passed++;
  endtask

  task automatic test_clear();
    apply(0, 0, 0, 0, 1, 0, 0, ro, re);
    apply(1, 0, 127, 0, 0, 0, 0, ro, re);
    apply(1, 0, 1, 0, 0, 0, 0, ro, re);
    total++; if (s_sticky[0] !== 1'b1) $display("FAIL clr_pre_sticky: got %b want 1", s_sticky[0]); else passed++;
    apply(1, 0, 5, 0, 1, 0, 0, ro, re);
    total++; if (sv(s_out_sum) != 5 || s_sticky[0] !== 1'b0 || sv(w_out_sum) != 5)
      $display("FAIL clr_same_ch: sum=%0d wsum=%0d sticky0=%b want 5 5 0",
               sv(s_out_sum), sv(w_out_sum), s_sticky[0]); else passed++;
    apply(1, 1, 3, 0, 1, 0, 2, ro, re);
    total++; if (sv(s_out_sum) != exp_sum[0] || s_sticky !== stk_vec(0))
      $display("FAIL clr_other_ch: sum=%0d sticky=%b want %0d %b", sv(s_out_sum), s_sticky, exp_sum[0], stk_vec(0)); else passed++;
    apply(1, 2, 0, 0, 0, 0, 0, ro, re);
    total++; if (sv(s_out_sum) != 0 || sv(w_out_sum) != 0)
      $display("FAIL clr_ch2_zero: sum=%0d wsum=%0d want 0", sv(s_out_sum), sv(w_out_sum)); else passed++;
    apply(1, 3, 9, 0, 1, 1, 0, ro, re);
    total++; if (sv(s_out_sum) != 9 || s_sticky !== '0 || w_sticky !== '0)
      $display("FAIL clr_all: sum=%0d sticky=%b/%b want 9 0000", sv(s_out_sum), s_sticky, w_sticky); else passed++;
  endtask

  task automatic test_reset_pending();
    out_ready = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0, ro, re);
    out_ready = 1'b0;
    apply(1, 1, 50, 0, 0, 0, 0, ro, re);
    total++; if (s_out_valid !== 1'b1) $display("FAIL rstp_pending: valid=%b want 1", s_out_valid); else passed++;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    total++; if (s_out_valid !== 1'b0 || s_out_sum !== '0 || s_out_ch !== '0 || s_out_sat !== 1'b0 || s_sticky !== '0)
      $display("FAIL rstp_outputs: valid=%b sum=%h ch=%h sat=%b sticky=%b want all 0",
               s_out_valid, s_out_sum, s_out_ch, s_out_sat, s_sticky); else passed++;
    total++; if (s_in_ready !== 1'b0) $display("FAIL rstp_in_ready: got %b want 0", s_in_ready); else passed++;
    rst_n = 1'b1;
    out_ready = 1'b1;
    apply(1, 0, 7, 0, 0, 0, 0, ro, re);
    total++; if (sv(s_out_sum) != 7 || s_out_ch !== 2'd0 || s_out_valid !== 1'b1)
      $display("FAIL rstp_after: sum=%0d ch=%0d valid=%b want 7 0 1", sv(s_out_sum), s_out_ch, s_out_valid); else passed++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      bit c;
      c = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      apply(bit'($urandom_range(0, 4) != 0), int'($urandom_range(0, NCH - 1)),
            int'($urandom_range(0, 255)) - 128, bit'($urandom_range(0, 1)),
            c, c && ($urandom_range(0, 2) == 0), int'($urandom_range(0, NCH - 1)), ro, re);
      total++;
      if (ro !== re || s_out_valid !== m_ov || s_sticky !== stk_vec(0) || w_sticky !== stk_vec(1) ||
          (m_ov && (sv(s_out_sum) != exp_sum[0] || s_out_sat !== exp_sat[0] || s_out_ch !== CHW'(exp_ch) ||
                    sv(w_out_sum) != exp_sum[1] || w_out_sat !== exp_sat[1]))) begin
        errs++;
        if (errs <= 5)
          $display("FAIL rand[%0d]: rdy=%b/%b valid=%b/%b sum=%0d/%0d wsum=%0d/%0d sat=%b/%b ch=%0d/%0d stk=%b/%b",
                   i, ro, re, s_out_valid, m_ov, sv(s_out_sum), exp_sum[0], sv(w_out_sum), exp_sum[1],
                   s_out_sat, exp_sat[0], s_out_ch, exp_ch, s_sticky, stk_vec(0));
      end else begin
        passed++;
      end
    end
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_saturate_pos();
    test_sub_min();
    test_saturate_neg();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_reset_pending();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
